// File: rtl/spi_slave_regfile_pkg.sv
// Shared SPI definitions: FSM state encoding, field widths, address range helper.
// Contents: spi_state_t (one-hot), SPI_ADDR_W, SPI_DATA_W, RW_BIT, addr_in_range().
// Used by the SPI responder and the SPI controller so both agree on the frame format.
package spi_pkg;

  localparam int SPI_ADDR_W = 7;
  localparam int SPI_DATA_W = 8;
  // Address byte bit that selects write (1) or read (0).
  localparam int RW_BIT     = 7;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ADDR  = 4'b0010,
    S_WDATA = 4'b0100,
    S_RDATA = 4'b1000
  } spi_state_t;

  // True when a 7-bit byte address falls inside a register file of 'depth' bytes.
  function automatic logic addr_in_range(input logic [SPI_ADDR_W-1:0] addr, input int depth);
    return int'({25'd0, addr}) < depth;
  endfunction

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between an SPI controller (master) and a responder (slave).
// Signals: sclk_i (idles high), mosi_i, cs_i (active-high select), miso_o.
// Modports: master drives sclk/mosi/cs and reads miso; slave the reverse.
interface spi_slave_regfile_if;
  logic sclk_i;
  logic mosi_i;
  logic cs_i;
  logic miso_o;

  modport master (output sclk_i, output mosi_i, output cs_i, input miso_o);
  modport slave  (input sclk_i, input mosi_i, input cs_i, output miso_o);
endinterface

// File: rtl/spi_slave_regfile_pin_sync.sv
// Synchroniser for one asynchronous pin plus a falling-edge pulse on the synchronised level.
// Ports: clk, rst_n (async active-low), din (raw pin), dout (synchronised level), fall (1-cycle pulse).
// dout lags din by SYNC_FF cycles; fall is decoded from one further flop, so it is acted on SYNC_FF+1 cycles after the pin.
module spi_pin_sync #(
  parameter int   SYNC_FF = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [SYNC_FF-1:0] chain;
  logic               last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_FF{RST_VAL}};
      last  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_FF-2:0], din};
      last  <= chain[SYNC_FF-1];
    end
  end

  assign dout = chain[SYNC_FF-1];
  assign fall = last & ~dout;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI responder with a local byte register file; all logic runs on pclk_i, SPI pins are oversampled.
// Ports: pclk_i, prst_n_i, spi (slave modport: sclk/mosi/cs in, miso out), loc_addr_i/loc_rdata_o (local read,
//        1-cycle latency), wr_valid_o/wr_addr_o/wr_data_o (committed SPI write pulse), frame_abort_o (partial frame).
// Frame: 8-bit address (LSB first, bit 7 = write), sclk held high for a gap, then 8 data bits; bursts while cs stays high.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int SYNC_FF = 2
) (
  input  logic                  pclk_i,
  input  logic                  prst_n_i,
  spi_slave_regfile_if.slave    spi,
  input  logic [SPI_ADDR_W-1:0] loc_addr_i,
  output logic [SPI_DATA_W-1:0] loc_rdata_o,
  output logic                  wr_valid_o,
  output logic [SPI_ADDR_W-1:0] wr_addr_o,
  output logic [SPI_DATA_W-1:0] wr_data_o,
  output logic                  frame_abort_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pin conditioning
  logic sclk_fall, sclk_lvl_unused;
  logic mosi_s, mosi_fall_unused;
  logic cs_s, cs_fall_unused;

  // sclk idles high, so its synchroniser resets high to avoid a false edge on reset release.
  spi_pin_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(pclk_i), .rst_n(prst_n_i), .din(spi.sclk_i), .dout(sclk_lvl_unused), .fall(sclk_fall)
  );
  spi_pin_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(pclk_i), .rst_n(prst_n_i), .din(spi.mosi_i), .dout(mosi_s), .fall(mosi_fall_unused)
  );
  spi_pin_sync #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sync_cs (
    .clk(pclk_i), .rst_n(prst_n_i), .din(spi.cs_i), .dout(cs_s), .fall(cs_fall_unused)
  );

  // Frame state
  spi_state_t            state;
  logic [2:0]            bit_cnt;
  logic [SPI_ADDR_W-1:0] addr_sr;
  logic [SPI_DATA_W-2:0] data_sr;   // bits 0..6; bit 7 is taken straight from mosi_s
  logic [SPI_DATA_W-1:0] tx_sr;
  logic                  miso;

  logic [SPI_DATA_W-1:0] mem [DEPTH];

  logic                  last_bit;
  logic                  addr_ok;
  logic                  loc_ok;
  logic                  commit;
  logic [SPI_DATA_W-1:0] wbyte;
  logic [SPI_DATA_W-1:0] spi_rbyte;

  assign last_bit  = sclk_fall && (bit_cnt == 3'd7);
  assign addr_ok   = addr_in_range(addr_sr, DEPTH);
  assign loc_ok    = addr_in_range(loc_addr_i, DEPTH);
  assign wbyte     = {mosi_s, data_sr};
  assign spi_rbyte = addr_ok ? mem[addr_sr[IDX_W-1:0]] : '0;
  // A cs drop in the same cycle as the last data bit is treated as an abort, so commit needs cs_s.
  assign commit    = (state == S_WDATA) && cs_s && last_bit;

  assign spi.miso_o = miso;

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      addr_sr       <= '0;
      data_sr       <= '0;
      tx_sr         <= '0;
      miso          <= 1'b1;
      wr_valid_o    <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      frame_abort_o <= 1'b0;
    end else begin
      wr_valid_o    <= 1'b0;
      frame_abort_o <= 1'b0;
      if (!cs_s && (state != S_IDLE)) begin
        // Leaving S_ADDR with bit_cnt == 0 is a clean frame boundary; anything else is partial.
        frame_abort_o <= (state != S_ADDR) || (bit_cnt != 3'd0);
        state         <= S_IDLE;
        bit_cnt       <= '0;
        miso          <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            miso    <= 1'b1;
            bit_cnt <= '0;
            if (cs_s) state <= S_ADDR;
          end
          S_ADDR: if (sclk_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              addr_sr[bit_cnt] <= mosi_s;
            end else if (mosi_s) begin
              state <= S_WDATA;
            end else begin
              // First read bit goes out now and is held through the inter-phase gap.
              tx_sr <= spi_rbyte;
              miso  <= spi_rbyte[0];
              state <= S_RDATA;
            end
          end
          S_WDATA: if (sclk_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              data_sr[bit_cnt] <= mosi_s;
            end else begin
              wr_valid_o <= 1'b1;
              wr_addr_o  <= addr_sr;
              wr_data_o  <= wbyte;
              // cs_s is known high here; a later drop in S_ADDR returns to idle without an abort.
              state      <= S_ADDR;
            end
          end
          S_RDATA: if (sclk_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sr   <= {1'b1, tx_sr[SPI_DATA_W-1:1]};
            if (bit_cnt == 3'd7) begin
              miso  <= 1'b1;
              state <= S_ADDR;
            end else begin
              miso  <= tx_sr[1];
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Register file. The local read sees the pre-write value when it hits the byte being written.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      loc_rdata_o <= '0;
    end else begin
      if (commit && addr_ok) mem[addr_sr[IDX_W-1:0]] <= wbyte;
      loc_rdata_o <= loc_ok ? mem[loc_addr_i[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: models the SPI controller (LSB first, 4-SCLK gap, pclk = 10x SCLK).
// A table of whole frames with hand-computed results, plus sequences for abort, same-cycle read/write and reset.
// Read data is sampled while sclk is high before each data falling edge, i.e. at the preceding rising edge.
module tb_spi_slave_regfile;

  logic       pclk = 1'b0;
  logic       prst_n;
  logic [6:0] loc_addr;
  logic [7:0] loc_rdata;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_abort;

  spi_slave_regfile_if bus ();

  spi_slave_regfile #(.DEPTH(64), .SYNC_FF(2)) dut (
    .pclk_i(pclk), .prst_n_i(prst_n), .spi(bus),
    .loc_addr_i(loc_addr), .loc_rdata_o(loc_rdata),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .frame_abort_o(frame_abort)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_err    = 0;

  // Event monitor, sampled 1 ns after each rising edge.
  int         wr_cnt = 0;
  int         abort_cnt = 0;
  logic [6:0] wr_a;
  logic [7:0] wr_d;
  logic [7:0] wr_snap;   // loc_rdata_o in the cycle the write pulse is seen
  always @(posedge pclk) begin
    #1;
    if (wr_valid) begin
      wr_cnt++;
      wr_a    = wr_addr;
      wr_d    = wr_data;
      wr_snap = loc_rdata;
    end
    if (frame_abort) abort_cnt++;
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdat;
    logic       keep_cs;
    logic [7:0] exp_rd;
    logic [6:0] loc_a;
    logic [7:0] exp_loc;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Shift nbits of tx out LSB first; rx[i] is miso as seen just before falling edge i.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      rx[i] = bus.miso_o;
      bus.mosi_i = tx[i];
      tick(5);
      bus.sclk_i = 1'b0;
      tick(5);
      bus.sclk_i = 1'b1;
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    logic [7:0] rx;
    int         wr0;
    int         ab0;
    if (!bus.cs_i) begin
      bus.cs_i = 1'b1;
      tick(4);
    end
    wr0 = wr_cnt;
    ab0 = abort_cnt;
    spi_byte(v.addr, 8, rx);
    tick(40);
    spi_byte(v.addr[7] ? v.wdat : 8'h00, 8, rx);
    tick(5);
    if (v.addr[7]) begin
      checki($sformatf("v%0d_wr_count", idx), wr_cnt, wr0 + 1);
      check8($sformatf("v%0d_wr_addr", idx), {1'b0, wr_a}, {1'b0, v.addr[6:0]});
      check8($sformatf("v%0d_wr_data", idx), wr_d, v.wdat);
    end else begin
      check8($sformatf("v%0d_rd_data", idx), rx, v.exp_rd);
      check8($sformatf("v%0d_miso_after", idx), {7'd0, bus.miso_o}, 8'h01);
      checki($sformatf("v%0d_no_write", idx), wr_cnt, wr0);
    end
    if (!v.keep_cs) begin
      bus.cs_i = 1'b0;
      tick(8);
    end else begin
      tick(20);
    end
    checki($sformatf("v%0d_no_abort", idx), abort_cnt, ab0);
    loc_addr = v.loc_a;
    tick(2);
    check8($sformatf("v%0d_loc_rdata", idx), loc_rdata, v.exp_loc);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int         wr0;
    int         ab0;
    vec_t       v;

    // addr, wdat, keep_cs, exp_rd, loc_a, exp_loc  (DEPTH = 64)
    vecs[0] = '{8'h85, 8'hA5, 1'b0, 8'h00, 7'h05, 8'hA5};  // write mem[5]=A5
    vecs[1] = '{8'h05, 8'h00, 1'b0, 8'hA5, 7'h05, 8'hA5};  // read back A5
    vecs[2] = '{8'h80, 8'h11, 1'b1, 8'h00, 7'h00, 8'h11};  // burst: write mem[0]=11
    vecs[3] = '{8'h81, 8'h22, 1'b1, 8'h00, 7'h01, 8'h22};  // burst: write mem[1]=22
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h11, 7'h01, 8'h22};  // burst: read mem[0]
    vecs[5] = '{8'hFF, 8'h77, 1'b0, 8'h00, 7'h3F, 8'h00};  // out of range: dropped, no alias to 3F
    vecs[6] = '{8'h7F, 8'h00, 1'b0, 8'h00, 7'h7F, 8'h00};  // out-of-range read gives 00
    vecs[7] = '{8'h01, 8'h00, 1'b0, 8'h22, 7'h00, 8'h11};  // mem[1] still 22

    prst_n     = 1'b0;
    bus.cs_i   = 1'b0;
    bus.sclk_i = 1'b1;
    bus.mosi_i = 1'b0;
    loc_addr   = 7'd0;
    tick(3);
    prst_n = 1'b1;
    tick(2);

    check8("rst_miso",      {7'd0, bus.miso_o}, 8'h01);
    check8("rst_loc_rdata", loc_rdata, 8'h00);
    check8("rst_wr_valid",  {7'd0, wr_valid}, 8'h00);
    check8("rst_wr_addr",   {1'b0, wr_addr}, 8'h00);
    check8("rst_wr_data",   wr_data, 8'h00);
    check8("rst_abort",     {7'd0, frame_abort}, 8'h00);

    for (int i = 0; i < 8; i++) run_frame(i, vecs[i]);

    // cs dropped after 5 address bits.
    wr0 = wr_cnt;
    ab0 = abort_cnt;
    bus.cs_i = 1'b1;
    tick(4);
    spi_byte(8'h83, 5, rx);
    tick(3);
    bus.cs_i = 1'b0;
    tick(8);
    checki("abort_addr_pulse", abort_cnt, ab0 + 1);
    checki("abort_addr_no_wr", wr_cnt, wr0);
    check8("abort_addr_miso", {7'd0, bus.miso_o}, 8'h01);

    // cs dropped in the gap after a complete write address: still a partial frame.
    ab0 = abort_cnt;
    bus.cs_i = 1'b1;
    tick(4);
    spi_byte(8'h84, 8, rx);
    tick(10);
    bus.cs_i = 1'b0;
    tick(8);
    checki("abort_gap_pulse", abort_cnt, ab0 + 1);
    checki("abort_gap_no_wr", wr_cnt, wr0);

    // Full write after the aborts; loc_addr already on byte 3 so the write cycle shows the old value.
    loc_addr = 7'h03;
    tick(2);
    v = '{8'h83, 8'h3C, 1'b0, 8'h00, 7'h03, 8'h3C};
    run_frame(8, v);
    check8("same_cycle_old_value", wr_snap, 8'h00);

    // Reset in the middle of a write data phase.
    loc_addr = 7'h05;
    bus.cs_i = 1'b1;
    tick(4);
    spi_byte(8'h85, 8, rx);
    tick(40);
    spi_byte(8'h99, 3, rx);
    tick(2);
    wr0 = wr_cnt;
    ab0 = abort_cnt;
    #2 prst_n = 1'b0;
    #1;
    check8("rst_async_loc_rdata", loc_rdata, 8'h00);
    check8("rst_async_wr_data",   wr_data, 8'h00);
    bus.cs_i   = 1'b0;
    bus.mosi_i = 1'b0;
    tick(2);
    prst_n = 1'b1;
    tick(2);
    check8("rst2_miso",      {7'd0, bus.miso_o}, 8'h01);
    check8("rst2_wr_valid",  {7'd0, wr_valid}, 8'h00);
    check8("rst2_wr_addr",   {1'b0, wr_addr}, 8'h00);
    check8("rst2_wr_data",   wr_data, 8'h00);
    check8("rst2_abort",     {7'd0, frame_abort}, 8'h00);
    check8("rst2_mem5",      loc_rdata, 8'h00);
    checki("rst2_no_wr",     wr_cnt, wr0);
    checki("rst2_no_abort",  abort_cnt, ab0);

    v = '{8'h86, 8'h5A, 1'b0, 8'h00, 7'h06, 8'h5A};
    run_frame(9, v);
    v = '{8'h06, 8'h00, 1'b0, 8'h5A, 7'h05, 8'h00};
    run_frame(10, v);
    v = '{8'h05, 8'h00, 1'b0, 8'h00, 7'h03, 8'h00};
    run_frame(11, v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
